// File: rtl/hms_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hms_counter_pkg
// Description : Shared defaults and direction encoding for the h:m:s counter.
// Revision    : 1.0 - initial release
// ============================================================================
package hms_counter_pkg;

    localparam int DEF_SEC_MOD = 60;
    localparam int DEF_MIN_MOD = 60;
    localparam int DEF_HR_MOD  = 24;
    localparam int DEF_SEC_W   = 6;
    localparam int DEF_MIN_W   = 6;
    localparam int DEF_HR_W    = 5;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : hms_counter_pkg
`default_nettype wire

// File: rtl/hms_counter_mod_stage.sv
`default_nettype none
// ============================================================================
// Module      : mod_stage
// Description : One up/down modulo stage with clamped load, comb wrap and
//               registered roll pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_stage
    import hms_counter_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_step,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap,
    output logic             o_roll
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_roll;
    logic             w_at_edge;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    always_comb begin
        w_at_edge  = (i_dir == DIR_UP) ? (r_count == C_MAX) : (r_count == '0);
        o_wrap     = i_step & w_at_edge;
        w_step_val = '0;
        if (i_dir == DIR_UP) begin
            w_step_val = w_at_edge ? '0 : r_count + WIDTH'(1);
        end else begin
            w_step_val = w_at_edge ? C_MAX : r_count - WIDTH'(1);
        end
        // Compare in 32 bits so MODULUS == 2**WIDTH does not overflow.
        w_load_val = (32'(i_load_val) >= 32'(MODULUS)) ? C_MAX : i_load_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_roll  <= 1'b0;
        end else if (i_load) begin
            r_count <= w_load_val;
            r_roll  <= 1'b0;
        end else if (i_step) begin
            r_count <= w_step_val;
            r_roll  <= w_at_edge;
        end else begin
            r_roll  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_roll  = r_roll;

endmodule : mod_stage
`default_nettype wire

// File: rtl/hms_counter.sv
`default_nettype none
// ============================================================================
// Module      : hms_counter
// Description : Cascaded hours/minutes/seconds up/down counter with load.
// Revision    : 1.0 - initial release
// ============================================================================
module hms_counter
    import hms_counter_pkg::*;
#(
    parameter int SEC_MOD = DEF_SEC_MOD,
    parameter int MIN_MOD = DEF_MIN_MOD,
    parameter int HR_MOD  = DEF_HR_MOD,
    parameter int SEC_W   = DEF_SEC_W,
    parameter int MIN_W   = DEF_MIN_W,
    parameter int HR_W    = DEF_HR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [MIN_W-1:0] load_min,
    input  logic [HR_W-1:0]  load_hr,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic             sec_roll,
    output logic             min_roll,
    output logic             hr_roll
);

    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap_unused;

    // Wraps are combinational so the whole cascade settles on one edge.
    mod_stage #(.WIDTH(SEC_W), .MODULUS(SEC_MOD)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .i_step     (enable),
        .i_dir      (up_down),
        .i_load     (load),
        .i_load_val (load_sec),
        .o_count    (seconds),
        .o_wrap     (w_sec_wrap),
        .o_roll     (sec_roll)
    );

    mod_stage #(.WIDTH(MIN_W), .MODULUS(MIN_MOD)) u_min (
        .clk        (clk),
        .reset      (reset),
        .i_step     (w_sec_wrap),
        .i_dir      (up_down),
        .i_load     (load),
        .i_load_val (load_min),
        .o_count    (minutes),
        .o_wrap     (w_min_wrap),
        .o_roll     (min_roll)
    );

    mod_stage #(.WIDTH(HR_W), .MODULUS(HR_MOD)) u_hr (
        .clk        (clk),
        .reset      (reset),
        .i_step     (w_min_wrap),
        .i_dir      (up_down),
        .i_load     (load),
        .i_load_val (load_hr),
        .o_count    (hours),
        .o_wrap     (w_hr_wrap_unused),
        .o_roll     (hr_roll)
    );

endmodule : hms_counter
`default_nettype wire

// File: tb/tb_hms_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hms_counter
// Description : Scoreboard bench for hms_counter against a seconds-of-day model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hms_counter;

    localparam int SM    = 60;
    localparam int MM    = 60;
    localparam int HM    = 24;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int DAY   = SM * MM * HM;

    typedef struct packed {
        logic [HR_W-1:0]  h;
        logic [MIN_W-1:0] m;
        logic [SEC_W-1:0] s;
        logic             hr;
        logic             mr;
        logic             sr;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset, enable, up_down, load;
    logic [SEC_W-1:0] load_sec;
    logic [MIN_W-1:0] load_min;
    logic [HR_W-1:0]  load_hr;
    logic [SEC_W-1:0] seconds;
    logic [MIN_W-1:0] minutes;
    logic [HR_W-1:0]  hours;
    logic             sec_roll, min_roll, hr_roll;

    obs_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    // Model: time of day as a single seconds count, wraps by modular arithmetic.
    int   m_t = 0;

    hms_counter #(
        .SEC_MOD(SM), .MIN_MOD(MM), .HR_MOD(HM),
        .SEC_W(SEC_W), .MIN_W(MIN_W), .HR_W(HR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .up_down  (up_down),
        .load     (load),
        .load_sec (load_sec),
        .load_min (load_min),
        .load_hr  (load_hr),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
        .sec_roll (sec_roll),
        .min_roll (min_roll),
        .hr_roll  (hr_roll)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input int v, input int modulus);
        return (v >= modulus) ? modulus - 1 : v;
    endfunction

    task automatic drive(input bit rs, input bit en, input bit ud, input bit ld,
                         input int ls, input int lm, input int lh);
        obs_t e;
        bit   sr, mr, hr;
        @(negedge clk);
        reset    = rs;
        enable   = en;
        up_down  = ud;
        load     = ld;
        load_sec = SEC_W'(ls);
        load_min = MIN_W'(lm);
        load_hr  = HR_W'(lh);
        sr = 1'b0; mr = 1'b0; hr = 1'b0;
        if (rs) begin
            m_t = 0;
        end else if (ld) begin
            m_t = (clampv(int'(load_hr), HM) * MM + clampv(int'(load_min), MM)) * SM
                  + clampv(int'(load_sec), SM);
        end else if (en) begin
            if (ud) begin
                m_t = (m_t + 1) % DAY;
                sr = (m_t % SM) == 0;
                mr = (m_t % (SM * MM)) == 0;
                hr = (m_t == 0);
            end else begin
                sr = (m_t % SM) == 0;
                mr = (m_t % (SM * MM)) == 0;
                hr = (m_t == 0);
                m_t = (m_t + DAY - 1) % DAY;
            end
        end
        e.h  = HR_W'(m_t / (SM * MM));
        e.m  = MIN_W'((m_t / SM) % MM);
        e.s  = SEC_W'(m_t % SM);
        e.hr = hr;
        e.mr = mr;
        e.sr = sr;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit en, input bit ud);
        for (int i = 0; i < n; i++) drive(1'b0, en, ud, 1'b0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a result every cycle, one edge after each drive.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hours, minutes, seconds, hr_roll, min_roll, sec_roll};
                n_vec++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL vec%0d t=%0t: got %0d:%0d:%0d roll(h,m,s)=%b%b%b, expected %0d:%0d:%0d roll(h,m,s)=%b%b%b",
                             n_vec, $time, a.h, a.m, a.s, a.hr, a.mr, a.sr,
                             e.h, e.m, e.s, e.hr, e.mr, e.sr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, vectors=%0d", n_vec);
            $fatal(1, "timeout");
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        load_sec = '0; load_min = '0; load_hr = '0;

        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 5, 5, 5);

        // Seconds rollover into minutes
        run(61, 1, 1);

        // Full day wrap upward
        drive(0, 0, 1, 1, 58, 59, 23);
        run(3, 1, 1);

        // Full borrow downward from zero
        drive(1, 0, 0, 0, 0, 0, 0);
        run(2, 1, 0);

        // Clamped load, then load beating enable
        drive(0, 0, 1, 1, 63, 60, 31);
        drive(0, 1, 1, 1, 5, 6, 7);
        drive(0, 1, 0, 1, 0, 0, 0);
        run(1, 1, 0);

        // Hold, then direction changes
        drive(1, 0, 1, 0, 0, 0, 0);
        run(30, 1, 1);
        run(3, 0, 1);
        run(2, 0, 0);
        run(2, 1, 1);
        run(1, 1, 0);

        // Reset dominates load and enable
        drive(0, 0, 1, 1, 59, 34, 12);
        drive(1, 1, 1, 1, 59, 34, 12);
        run(3, 1, 1);

        // Random mix across full field widths
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            drive(r == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                  r >= 1 && r <= 3,
                  $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31));
        end

        // Random runs near the day boundary to exercise cascaded wraps
        for (int k = 0; k < 20; k++) begin
            bit ud = $urandom_range(0, 1) != 0;
            if (ud) drive(0, 0, 1, 1, $urandom_range(55, 59), 59, 23);
            else    drive(0, 0, 0, 1, $urandom_range(0, 4), 0, 0);
            run($urandom_range(3, 8), 1, ud);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_hms_counter
`default_nettype wire

// File: doc/hms_counter.md
Name: hms_counter

Overview:
Parametrised cascaded hours/minutes/seconds counter, next generation of the single-stage seconds counter.
- Three modulo stages (sec -> min -> hr), each with a configurable modulus and width.
- Adds count direction (up/down), synchronous parallel load with range clamping, and a per-stage single-cycle rollover/borrow pulse.
- Sits behind the 1 Hz tick generator and feeds the display/alarm logic.

Parameters:
SEC_MOD, 60, seconds stage modulus (count range 0..SEC_MOD-1)
MIN_MOD, 60, minutes stage modulus
HR_MOD, 24, hours stage modulus
SEC_W, 6, seconds field width; requires SEC_MOD <= 2**SEC_W
MIN_W, 6, minutes field width; requires MIN_MOD <= 2**MIN_W
HR_W, 5, hours field width; requires HR_MOD <= 2**HR_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  count tick; one step per cycle while high
up_down  in  1  1 = count up, 0 = count down; sampled every cycle
load  in  1  parallel load strobe
load_sec  in  SEC_W  seconds load value
load_min  in  MIN_W  minutes load value
load_hr  in  HR_W  hours load value
seconds  out  SEC_W  registered seconds count
minutes  out  MIN_W  registered minutes count
hours  out  HR_W  registered hours count
sec_roll  out  1  registered pulse: seconds stage wrapped this edge
min_roll  out  1  registered pulse: minutes stage wrapped this edge
hr_roll  out  1  registered pulse: hours stage wrapped (day boundary)

Behaviour:
- Reset: seconds, minutes and hours = 0; all roll outputs = 0. Reset has priority over load and enable. Reset mid-count clears everything on that edge; no pulse is emitted.
- Priority per edge: reset > load > enable > hold.
- Load: each field takes its load value. A value >= its modulus is clamped to MOD-1. All roll outputs are 0 on a load cycle. A load ignores enable that cycle.
- Up step (enable=1, up_down=1):
  - seconds +1. At SEC_MOD-1 it wraps to 0 and the seconds carry is asserted.
  - Minutes step only when the seconds carry is asserted. Hours step only when the minutes carry is asserted.
  - Carries are combinational wrap conditions, so the whole cascade updates on the same edge. Example: 00:59:59 -> 01:00:00 in one cycle.
- Down step (enable=1, up_down=0):
  - seconds -1. At 0 it wraps to SEC_MOD-1 and the seconds borrow is asserted.
  - The borrow cascades the same way. Example: 00:00:00 -> (HR_MOD-1):(MIN_MOD-1):(SEC_MOD-1).
- Roll outputs:
  - Registered, and high on exactly the edge where the corresponding stage wraps, concurrent with the wrapped value.
  - Otherwise 0, including when enable=0. Pulse width is 1 cycle per wrap.
  - A cascaded wrap raises all affected pulses together (sec_roll, min_roll and hr_roll on the same cycle).
- enable=0: counts hold and roll outputs go to 0.
- up_down may change on any cycle. Each edge uses the current value; there is no pipeline.
- Latency: outputs reflect the inputs of the preceding edge (1 cycle).
- Arithmetic: each stage is computed in its own width. Values never exceed MOD-1 after reset or load.

Decomposition:
- Shared package/header: default moduli (60, 60, 24) and widths, plus a direction encoding constant (DIR_UP = 1).
- Natural sub-module: mod_stage. Parameters WIDTH and MODULUS. Inputs: step, dir, load, load_val. Outputs: count, wrap (comb), roll (registered).
- hms_counter instantiates three mod_stage and chains their wrap outputs into the next stage's step.

Test Plan:
- Reset then 59 enabled up cycles -> seconds=59, min=0, sec_roll=0. The 60th cycle -> seconds=0, minutes=1, sec_roll=1 for exactly 1 cycle.
- Load 23:59:58, enable up 2 cycles -> 23:59:59, then 00:00:00 with sec_roll=min_roll=hr_roll=1 on the same cycle, all 0 the next cycle.
- From reset, enable down 1 cycle -> 23:59:59 with all three roll pulses = 1. Next down step -> 23:59:58, pulses = 0.
- Load sec=63, min=60, hr=31 -> registers read 59/59/23. Load with enable=1 the same cycle -> load wins, no step, roll outputs = 0.
- Count to 00:00:30, deassert enable 5 cycles -> value held, roll=0. Toggle up_down mid-run: up, up, down -> 00:00:31, 00:00:32, 00:00:31.
- Assert reset at 12:34:59 together with enable and load -> 00:00:00 and all roll outputs = 0 on that edge. Counting resumes from 0 after reset drops.
